// File: rtl/irq_ctl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctl_pkg
// Shared definitions for the interrupt request controller:
//   - software register addresses (MASK, PEND, CUR, SWI)
//   - controller state encoding (IDLE, REQ, SERVICE)
//   - position of the busy flag inside the CUR register
// -----------------------------------------------------------------------------
package irq_ctl_pkg;

    // Register map, selected by reg_addr
    localparam logic [1:0] IRQ_MASK = 2'd0;   // RW, 1 = source enabled
    localparam logic [1:0] IRQ_PEND = 2'd1;   // R, write-1-to-clear
    localparam logic [1:0] IRQ_CUR  = 2'd2;   // R, {busy, ..., irq_vec}
    localparam logic [1:0] IRQ_SWI  = 2'd3;   // W, write-1-to-set PEND; reads 0

    // Bit of CUR that reports "a request is outstanding or being serviced"
    localparam int CUR_BUSY_BIT = 31;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_SERV = 2'd2
    } ic_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-first priority encoder, purely combinational.
// Ports:
//   req : N_SRC request vector
//   idx : VW-bit index of the lowest set bit of req (0 when req is empty)
//   any : 1 when at least one bit of req is set
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int VW    = 5
) (
    input  logic [N_SRC-1:0] req,
    output logic [VW-1:0]    idx,
    output logic             any
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    // NOTE: idx gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_ctl.sv
// -----------------------------------------------------------------------------
// irq_ctl
// Interrupt request controller: source end of the irq/iack handshake with the
// core control FSM. Rising edges on the peripheral lines are latched into
// PEND, qualified by MASK, and the lowest-index enabled source is presented to
// the core one request at a time with a frozen vector.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-low reset
//   src_irq   : N_SRC peripheral interrupt lines (rising edge = event)
//   iack      : acknowledge from the control FSM (rise = IRQ entry, fall = RET)
//   irq       : registered request to the control FSM
//   irq_vec   : registered index of the requested / serviced source
//   reg_we    : register write strobe
//   reg_addr  : register select (MASK, PEND, CUR, SWI)
//   reg_wdata : register write data
//   reg_rdata : register read data, combinational from reg_addr
// -----------------------------------------------------------------------------
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             iack,
    output logic             irq,
    output logic [VW-1:0]    irq_vec,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata
);

    localparam logic [N_SRC-1:0] SRC_ONE = N_SRC'(1);

    ic_state_t          state;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   pend;
    logic [N_SRC-1:0]   src_q;

    logic [N_SRC-1:0]   wdata_src;
    logic               wr_mask;
    logic               wr_pend;
    logic               wr_swi;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   sw_clr;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   swi_set;
    logic [N_SRC-1:0]   pend_next;
    logic [N_SRC-1:0]   active;
    logic [VW-1:0]      prio_idx;
    logic               prio_any;

    // Write-data bits above N_SRC have no destination.
    logic               unused_wdata;
    assign unused_wdata = ^reg_wdata;

    assign wdata_src = reg_wdata[N_SRC-1:0];
    assign wr_mask   = reg_we && (reg_addr == IRQ_MASK);
    assign wr_pend   = reg_we && (reg_addr == IRQ_PEND);
    assign wr_swi    = reg_we && (reg_addr == IRQ_SWI);

    assign rise    = src_irq & ~src_q;
    assign sw_clr  = wr_pend ? wdata_src : '0;
    assign swi_set = wr_swi  ? wdata_src : '0;

    // The serviced source is retired on the same edge that enters SERVICE.
    assign ack_clr = ((state == IC_REQ) && iack) ? (SRC_ONE << irq_vec) : '0;

    // Sets are OR-ed in after the clear so a new event in the same cycle
    // always survives.
    assign pend_next = (pend & ~(sw_clr | ack_clr)) | rise | swi_set;

    assign active = pend & mask;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .VW    (VW)
    ) u_prio_enc (
        .req (active),
        .idx (prio_idx),
        .any (prio_any)
    );

    // NOTE: every register here, including MASK, is cleared by the async
    // reset; there is no storage array that could be left uninitialised.
    // NOTE: state is updated with non-blocking assignments so all flops
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
            pend  <= '0;
            mask  <= '0;
        end else begin
            src_q <= src_irq;
            pend  <= pend_next;
            if (wr_mask) begin
                mask <= wdata_src;
            end
        end
    end

    // Request/acknowledge FSM. irq and irq_vec are registered and frozen
    // from IDLE->REQ until the next request; later changes to MASK or PEND
    // never retract an issued request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IC_IDLE;
            irq     <= 1'b0;
            irq_vec <= '0;
        end else begin
            case (state)
                IC_IDLE: begin
                    // iack must be low so a late RET never looks like an ack.
                    if (prio_any && !iack) begin
                        state   <= IC_REQ;
                        irq     <= 1'b1;
                        irq_vec <= prio_idx;
                    end
                end
                IC_REQ: begin
                    if (iack) begin
                        state <= IC_SERV;
                        irq   <= 1'b0;
                    end
                end
                IC_SERV: begin
                    // iack falling marks the core's RET; no nesting before it.
                    if (!iack) begin
                        state <= IC_IDLE;
                    end
                end
                default: begin
                    state <= IC_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            IRQ_MASK: reg_rdata[N_SRC-1:0] = mask;
            IRQ_PEND: reg_rdata[N_SRC-1:0] = pend;
            IRQ_CUR: begin
                reg_rdata[CUR_BUSY_BIT] = (state != IC_IDLE);
                reg_rdata[VW-1:0]       = irq_vec;
            end
            default: reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctl
// Self-checking bench for irq_ctl (N_SRC=8, VW=5): a cycle table for the
// single-request and priority flows, hand sequences for masking, collision,
// software interrupts and async reset, then randomized traffic compared
// against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_irq_ctl;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_CUR  = 2'd2;
    localparam logic [1:0] A_SWI  = 2'd3;

    logic        clk;
    logic        rst;
    logic [7:0]  src_irq;
    logic        iack;
    logic        irq;
    logic [4:0]  irq_vec;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    int n_vec = 0;
    int n_err = 0;

    irq_ctl #(.N_SRC(8), .VW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq   (src_irq),
        .iack      (iack),
        .irq       (irq),
        .irq_vec   (irq_vec),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic        ack;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        e_irq;
        logic [4:0]  e_vec;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [7:0] s, input logic a, input logic w,
                                input logic [1:0] ad, input logic [31:0] wd,
                                input logic ei, input logic [4:0] ev,
                                input logic [31:0] er);
        vec_t v;
        v.src = s; v.ack = a; v.we = w; v.addr = ad; v.wdata = wd;
        v.e_irq = ei; v.e_vec = ev; v.e_rd = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] s, input logic a, input logic w,
                         input logic [1:0] ad, input logic [31:0] wd);
        src_irq   = s;
        iack      = a;
        reg_we    = w;
        reg_addr  = ad;
        reg_wdata = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack the outstanding request, then return; ends back in IDLE.
    task automatic ack_ret(input string tag);
        drive(8'h00, 1'b1, 1'b0, A_PEND, 32'h0);
        tick();
        drive(8'h00, 1'b0, 1'b0, A_CUR, 32'h0);
        check({tag, "_irq_dropped"}, {31'h0, irq}, 32'h0);
        tick();
        drive(8'h00, 1'b0, 1'b0, A_CUR, 32'h0);
        check({tag, "_busy_clear"}, {31'h0, reg_rdata[31]}, 32'h0);
        tick();
    endtask

    // ---------------- behavioural reference model ----------------
    bit [7:0] m_pend, m_mask, m_srcq;
    int       m_phase;     // 0 idle, 1 requesting, 2 in service
    bit       m_irq;
    int       m_vec;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] ad);
        case (ad)
            A_MASK:  return {24'h0, m_mask};
            A_PEND:  return {24'h0, m_pend};
            A_CUR:   return {(m_phase != 0), 26'h0, 5'(m_vec)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input bit [7:0] s, input bit a, input bit w,
                          input logic [1:0] ad, input logic [31:0] wd);
        bit [7:0] clr, rs, swi, nxt;
        rs  = s & ~m_srcq;
        clr = (w && ad == A_PEND) ? wd[7:0] : 8'h00;
        swi = (w && ad == A_SWI)  ? wd[7:0] : 8'h00;
        if (m_phase == 1 && a) clr[m_vec] = 1'b1;
        nxt = (m_pend & ~clr) | rs | swi;
        case (m_phase)
            0: if ((m_pend & m_mask) != 0 && !a) begin
                   m_vec = lowest(m_pend & m_mask); m_irq = 1'b1; m_phase = 1;
               end
            1: if (a) begin m_irq = 1'b0; m_phase = 2; end
            default: if (!a) m_phase = 0;
        endcase
        m_pend = nxt;
        if (w && ad == A_MASK) m_mask = wd[7:0];
        m_srcq = s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0]    r_src;
        bit          r_ack, r_we, core_busy;
        logic [1:0]  r_addr;
        logic [31:0] r_wd;

        // Single request, then priority between sources 2 and 5.
        tbl[0]  = mk(8'h00, 0, 1, A_MASK, 32'h01, 0, 0, 32'h0);
        tbl[1]  = mk(8'h01, 0, 0, A_MASK, 32'h0,  0, 0, 32'h1);
        tbl[2]  = mk(8'h00, 0, 0, A_PEND, 32'h0,  0, 0, 32'h1);
        tbl[3]  = mk(8'h00, 0, 0, A_CUR,  32'h0,  1, 0, 32'h8000_0000);
        tbl[4]  = mk(8'h00, 0, 0, A_PEND, 32'h0,  1, 0, 32'h1);
        tbl[5]  = mk(8'h00, 0, 0, A_PEND, 32'h0,  1, 0, 32'h1);
        tbl[6]  = mk(8'h00, 1, 0, A_CUR,  32'h0,  1, 0, 32'h8000_0000);
        tbl[7]  = mk(8'h00, 1, 0, A_PEND, 32'h0,  0, 0, 32'h0);
        tbl[8]  = mk(8'h00, 1, 0, A_CUR,  32'h0,  0, 0, 32'h8000_0000);
        tbl[9]  = mk(8'h00, 1, 0, A_CUR,  32'h0,  0, 0, 32'h8000_0000);
        tbl[10] = mk(8'h00, 1, 0, A_CUR,  32'h0,  0, 0, 32'h8000_0000);
        tbl[11] = mk(8'h00, 0, 0, A_CUR,  32'h0,  0, 0, 32'h8000_0000);
        tbl[12] = mk(8'h00, 0, 0, A_CUR,  32'h0,  0, 0, 32'h0);
        tbl[13] = mk(8'h00, 0, 1, A_MASK, 32'hFF, 0, 0, 32'h1);
        tbl[14] = mk(8'h24, 0, 0, A_MASK, 32'h0,  0, 0, 32'hFF);
        tbl[15] = mk(8'h00, 0, 0, A_PEND, 32'h0,  0, 0, 32'h24);
        tbl[16] = mk(8'h00, 1, 0, A_CUR,  32'h0,  1, 2, 32'h8000_0002);
        tbl[17] = mk(8'h00, 1, 0, A_PEND, 32'h0,  0, 2, 32'h20);
        tbl[18] = mk(8'h00, 0, 0, A_CUR,  32'h0,  0, 2, 32'h8000_0002);
        tbl[19] = mk(8'h00, 0, 0, A_CUR,  32'h0,  0, 2, 32'h2);
        tbl[20] = mk(8'h00, 1, 0, A_CUR,  32'h0,  1, 5, 32'h8000_0005);
        tbl[21] = mk(8'h00, 1, 0, A_PEND, 32'h0,  0, 5, 32'h0);
        tbl[22] = mk(8'h00, 0, 0, A_CUR,  32'h0,  0, 5, 32'h8000_0005);
        tbl[23] = mk(8'h00, 0, 0, A_SWI,  32'h0,  0, 5, 32'h0);

        // ---------------- reset state ----------------
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, A_MASK, 32'h0);
        repeat (3) tick();
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_vec", {27'h0, irq_vec}, 32'h0);
        check("rst_mask", reg_rdata, 32'h0);
        drive(8'h00, 1'b0, 1'b0, A_PEND, 32'h0);
        check("rst_pend", reg_rdata, 32'h0);
        drive(8'h00, 1'b0, 1'b0, A_CUR, 32'h0);
        check("rst_cur", reg_rdata, 32'h0);
        rst = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].src, tbl[i].ack, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            check($sformatf("tbl%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].e_irq});
            check($sformatf("tbl%0d_vec", i), {27'h0, irq_vec}, {27'h0, tbl[i].e_vec});
            check($sformatf("tbl%0d_rdata", i), reg_rdata, tbl[i].e_rd);
            tick();
        end

        // ---------------- masking ----------------
        drive(8'h00, 0, 1, A_MASK, 32'h00); tick();
        drive(8'h08, 0, 0, A_PEND, 32'h0);  tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("mask_pend", reg_rdata, 32'h08);
        tick();
        for (int i = 0; i < 50; i++) begin
            drive(8'h00, 0, 0, A_PEND, 32'h0);
            check("mask_irq_quiet", {31'h0, irq}, 32'h0);
            tick();
        end
        drive(8'h00, 0, 1, A_MASK, 32'h08);
        check("mask_wr_irq", {31'h0, irq}, 32'h0);
        tick();
        drive(8'h00, 0, 0, A_MASK, 32'h0);
        check("mask_edge1_irq", {31'h0, irq}, 32'h0);
        check("mask_readback", reg_rdata, 32'h08);
        tick();
        drive(8'h00, 0, 0, A_CUR, 32'h0);
        check("mask_edge2_irq", {31'h0, irq}, 32'h1);
        check("mask_vec", {27'h0, irq_vec}, 32'h3);
        tick();
        ack_ret("mask");

        // ---------------- collision ----------------
        drive(8'h00, 0, 1, A_MASK, 32'h02); tick();
        drive(8'h02, 0, 0, A_PEND, 32'h0);  tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("col_pend", reg_rdata, 32'h02);
        tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("col_irq", {31'h0, irq}, 32'h1);
        check("col_vec", {27'h0, irq_vec}, 32'h1);
        tick();
        drive(8'h02, 1, 0, A_PEND, 32'h0);   // ack and a new edge together
        tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("col_irq_low", {31'h0, irq}, 32'h0);
        check("col_pend_kept", reg_rdata, 32'h02);
        tick();
        drive(8'h00, 0, 0, A_CUR, 32'h0);
        check("col_idle", reg_rdata, 32'h1);
        tick();
        drive(8'h00, 0, 0, A_CUR, 32'h0);
        check("col_rereq_irq", {31'h0, irq}, 32'h1);
        check("col_rereq_cur", reg_rdata, 32'h8000_0001);
        tick();
        ack_ret("col");

        // ---------------- software interrupt ----------------
        drive(8'h00, 0, 1, A_MASK, 32'h10); tick();
        drive(8'h00, 0, 1, A_SWI,  32'h10);
        check("swi_reads0", reg_rdata, 32'h0);
        tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("swi_pend", reg_rdata, 32'h10);
        tick();
        drive(8'h00, 0, 1, A_PEND, 32'h10);
        check("swi_irq", {31'h0, irq}, 32'h1);
        check("swi_vec", {27'h0, irq_vec}, 32'h4);
        tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("swi_w1c_irq_held", {31'h0, irq}, 32'h1);
        check("swi_w1c_pend", reg_rdata, 32'h0);
        tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("swi_vec_held", {27'h0, irq_vec}, 32'h4);
        tick();
        ack_ret("swi");

        // ---------------- async reset while in REQ ----------------
        drive(8'h00, 0, 1, A_SWI, 32'h10); tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0); tick();
        drive(8'h00, 0, 0, A_PEND, 32'h0);
        check("rreq_irq", {31'h0, irq}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_irq", {31'h0, irq}, 32'h0);
        check("arst_vec", {27'h0, irq_vec}, 32'h0);
        check("arst_pend", reg_rdata, 32'h0);
        reg_addr = A_MASK; #1;
        check("arst_mask", reg_rdata, 32'h0);
        reg_addr = A_CUR; #1;
        check("arst_cur", reg_rdata, 32'h0);
        tick();
        rst = 1'b1;

        // ---------------- randomized against the model ----------------
        m_pend = 0; m_mask = 0; m_srcq = 0; m_phase = 0; m_irq = 0; m_vec = 0;
        core_busy = 0;
        r_src = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) r_src = 8'($urandom);
            if (core_busy) begin
                r_ack = 1'b1;
                if (!m_irq && $urandom_range(3) == 0) begin
                    r_ack = 1'b0;
                    core_busy = 1'b0;
                end
            end else if (m_irq && $urandom_range(2) == 0) begin
                r_ack = 1'b1;
                core_busy = 1'b1;
            end else begin
                r_ack = ($urandom_range(49) == 0);
            end
            r_we   = ($urandom_range(5) == 0);
            r_addr = 2'($urandom);
            r_wd   = $urandom;
            drive(r_src, r_ack, r_we, r_addr, r_wd);
            check("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
            check("rnd_vec", {27'h0, irq_vec}, 32'(m_vec));
            check("rnd_rdata", reg_rdata, m_read(r_addr));
            m_step(r_src, r_ack, r_we, r_addr, r_wd);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
